spi_cmd_master: RTL and testbench
=================================

# spi_cmd_master

Upstream driver for the SPI slave/RAM path. Accepts 10-bit command words (opcode in bits 9:8, payload in 7:0) over a valid/ready port, serialises each into a complete SPI frame on SS_n/MOSI, and, for read-data commands (opcode 2'b11), captures the 8-bit reply from MISO and returns it on a one-cycle result strobe. It runs on the same CLK as the slave, so no clock is forwarded.

## Interface
- TA_CYCLES, 2: SS_n-low cycles between the last MOSI bit and the first MISO sample (read-data only); range 1-15.
- GAP_CYCLES, 1: minimum SS_n-high cycles after every frame before the next frame may begin; range 1-15.

- CLK  in  1  system and SPI clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command word offered.
- cmd_word  in  10  command: [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
- cmd_ready  out  1  block can accept a command this cycle.
- rd_valid  out  1  one-cycle pulse: rd_data holds a captured read byte.
- rd_data  out  8  last captured read byte.
- busy  out  1  frame in progress (any state but IDLE).
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave, MSB first.
- MISO  in  1  serial data from slave, MSB first.

## Operation
- All outputs are registered or decoded from registered state; no combinational path from MISO to any output.
- Reset values: SS_n=1, MOSI=0, rd_valid=0, rd_data=8'h00, busy=0, state=IDLE. cmd_ready=0 while rst_n=0.
- States: IDLE, SELECT, OPBIT, SHIFT, TURN, RECV, GAP.
- IDLE: cmd_ready=1, SS_n=1, MOSI=0. On cmd_valid&&cmd_ready, latch cmd_word into a 10-bit shift register, go to SELECT.
- SELECT (1 cycle): SS_n=0, MOSI=0. Gives the slave its select-detect cycle. -> OPBIT.
- OPBIT (1 cycle): MOSI=word[9] (direction bit). -> SHIFT.
- SHIFT (10 cycles): MOSI=word[9], word[8], ... word[0], one bit per cycle; a 4-bit counter counts down 9..0. At count 0: opcode 11 -> TURN; otherwise -> GAP.
- TURN (TA_CYCLES cycles): SS_n=0, MOSI=0. -> RECV.
- RECV (8 cycles): sample MISO at the posedge ending each cycle into an 8-bit shift register, MSB first. After the 8th sample -> GAP, load rd_data, pulse rd_valid.
- GAP (GAP_CYCLES cycles): SS_n=1, MOSI=0. -> IDLE.
- cmd_valid while not ready is ignored; the command is not latched, and the source must hold it until accepted.
- The opcode does not constrain ordering: the block sends whatever is offered, including rd-data without a prior rd-addr.

## Timing
- Accept at posedge T. SS_n falls after T and stays low for 12 cycles (write/rd-addr) or 12+TA_CYCLES+8 cycles (rd-data).
- The first MOSI bit (the OPBIT copy of word[9]) is valid in the second SS_n-low cycle. word[0] is valid in the 12th.
- rd_valid is high for exactly the first GAP cycle, coincident with SS_n returning high. rd_data holds its value until the next capture.
- Command-to-command throughput: 12+GAP_CYCLES+1 cycles (write), 20+TA_CYCLES+GAP_CYCLES+1 cycles (rd-data).
- Reset mid-frame: at the posedge with rst_n=0, the frame is dropped. SS_n=1 and MOSI=0 on the following cycle, with no rd_valid pulse and rd_data cleared.
- rst_n and cmd_valid are both sampled at the same edge. Reset wins, and no command is accepted.

## Test plan
- Reset: rst_n=0 for 2 cycles with cmd_valid=1 -> SS_n=1, MOSI=0, rd_valid=0, rd_data=0, cmd_ready=0, no frame starts.
- Write address: cmd_word=10'b00_1101_0100 -> SS_n low 12 cycles; MOSI over those cycles = 0,0,0,0,1,1,0,1,0,1,0,0; busy=1 throughout; cmd_ready returns after GAP.
- Write data then read address: 10'b01_1111_0010 followed by 10'b10_1101_0100 held valid -> both frames sent; second accepted exactly 12+GAP_CYCLES+1 cycles after first; SS_n high ≥GAP_CYCLES between frames.
- Read data: cmd_word=10'b11_1010_1100, MISO driven 1,1,1,1,0,0,0,0 in the RECV window (TA_CYCLES=2) -> SS_n low 22 cycles; rd_valid one pulse; rd_data=8'hF0.
- Reset mid-frame: assert rst_n=0 during SHIFT bit 3 of a write-address frame -> SS_n=1 next cycle; after release, the next command produces a clean full frame.
- Backpressure: cmd_valid held with a changing cmd_word while busy -> only the word present at the cmd_ready edge is transmitted.

Source files
------------

// File: rtl/spi_cmd_master.sv
// SPI command master: serialises 10-bit command words into SS_n/MOSI frames
// and captures an 8-bit MISO reply for read-data commands.
module spi_cmd_master #(
   parameter int TA_CYCLES  = 2,
   parameter int GAP_CYCLES = 1
) (
   input  logic       CLK,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [9:0] cmd_word,
   output logic       cmd_ready,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SELECT = 3'd1;
   localparam logic [2:0] OPBIT  = 3'd2;
   localparam logic [2:0] SHIFT  = 3'd3;
   localparam logic [2:0] TURN   = 3'd4;
   localparam logic [2:0] RECV   = 3'd5;
   localparam logic [2:0] GAP    = 3'd6;

   localparam logic [3:0] TA_LAST  = 4'(TA_CYCLES - 1);
   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

   logic [2:0] state_r;
   logic [3:0] cnt_r;
   logic [9:0] sh_r;
   logic [7:0] rx_r;
   logic       is_rd_r;
   logic       ss_n_r;
   logic       mosi_r;
   logic       rd_valid_r;
   logic [7:0] rd_data_r;
   logic       ready_r;

   // Frame sequencer: every pin value is registered one edge ahead of its cycle.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= 4'd0;
         sh_r       <= 10'd0;
         rx_r       <= 8'd0;
         is_rd_r    <= 1'b0;
         ss_n_r     <= 1'b1;
         mosi_r     <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= 8'h00;
         ready_r    <= 1'b0;
      end else begin
         rd_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (cmd_valid && ready_r) begin
                  sh_r    <= cmd_word;
                  is_rd_r <= (cmd_word[9:8] == 2'b11);
                  ss_n_r  <= 1'b0;
                  mosi_r  <= 1'b0;
                  ready_r <= 1'b0;
                  state_r <= SELECT;
               end else begin
                  ss_n_r  <= 1'b1;
                  mosi_r  <= 1'b0;
                  ready_r <= 1'b1;
               end
            end
            SELECT: begin
               mosi_r  <= sh_r[9];
               state_r <= OPBIT;
            end
            OPBIT: begin
               mosi_r  <= sh_r[9];
               cnt_r   <= 4'd9;
               state_r <= SHIFT;
            end
            SHIFT: begin
               if (cnt_r == 4'd0) begin
                  mosi_r <= 1'b0;
                  if (is_rd_r) begin
                     cnt_r   <= TA_LAST;
                     state_r <= TURN;
                  end else begin
                     ss_n_r  <= 1'b1;
                     cnt_r   <= GAP_LAST;
                     state_r <= GAP;
                  end
               end else begin
                  // MOSI already shows sh_r[9]; the next bit out is sh_r[8].
                  mosi_r <= sh_r[8];
                  sh_r   <= {sh_r[8:0], 1'b0};
                  cnt_r  <= cnt_r - 4'd1;
               end
            end
            TURN: begin
               if (cnt_r == 4'd0) begin
                  cnt_r   <= 4'd7;
                  state_r <= RECV;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            RECV: begin
               rx_r <= {rx_r[6:0], MISO};
               if (cnt_r == 4'd0) begin
                  rd_data_r  <= {rx_r[6:0], MISO};
                  rd_valid_r <= 1'b1;
                  ss_n_r     <= 1'b1;
                  cnt_r      <= GAP_LAST;
                  state_r    <= GAP;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            GAP: begin
               if (cnt_r == 4'd0) begin
                  ready_r <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            default: begin
               ss_n_r  <= 1'b1;
               mosi_r  <= 1'b0;
               ready_r <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = ready_r;
   assign rd_valid  = rd_valid_r;
   assign rd_data   = rd_data_r;
   assign busy      = (state_r != IDLE);
   assign SS_n      = ss_n_r;
   assign MOSI      = mosi_r;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Self-checking bench for spi_cmd_master: directed frames plus random words,
// compared cycle by cycle against a frame model built from the timing rules.
module tb_spi_cmd_master;

   localparam int TA  = 2;
   localparam int GAP = 1;

   logic       CLK = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic [9:0] cmd_word;
   logic       cmd_ready;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       busy;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_rd = 8'h00;

   always #5 CLK = ~CLK;

   spi_cmd_master #(.TA_CYCLES(TA), .GAP_CYCLES(GAP)) dut (
      .CLK(CLK), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
      .cmd_ready(cmd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
      .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
   );

   task automatic check1(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Offer w, then check every cycle of the frame (index k counts cycles after
   // the accepting edge). hold keeps cmd_valid high with a scrambled word.
   // abort_at >= 0 asserts reset at that cycle and returns.
   task automatic run_frame(input logic [9:0] w, input logic [7:0] rx,
                            input bit hold, input int abort_at);
      bit   rd;
      int   flen;
      int   waited;
      logic e_mosi;
      waited = 0;
      while (cmd_ready !== 1'b1 && waited < 30) begin
         @(negedge CLK);
         waited++;
      end
      check1("ready_before_frame", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_word  = w;
      rd   = (w[9:8] == 2'b11);
      flen = 12 + (rd ? TA + 8 : 0);
      for (int k = 0; k <= flen + GAP; k++) begin
         @(negedge CLK);
         if (hold) cmd_word = 10'($urandom);
         else      cmd_valid = 1'b0;
         if (k == 1)                e_mosi = w[9];
         else if (k >= 2 && k <= 11) e_mosi = w[11 - k];
         else                       e_mosi = 1'b0;
         if (rd && k == flen) exp_rd = rx;
         check1($sformatf("ss_n w%h k%0d", w, k), SS_n, (k >= flen));
         check1($sformatf("mosi w%h k%0d", w, k), MOSI, e_mosi);
         check1($sformatf("busy w%h k%0d", w, k), busy, (k < flen + GAP));
         check1($sformatf("ready w%h k%0d", w, k), cmd_ready, (k == flen + GAP));
         check1($sformatf("rd_valid w%h k%0d", w, k), rd_valid, (rd && k == flen));
         check8($sformatf("rd_data w%h k%0d", w, k), rd_data, exp_rd);
         if (rd && k >= 12 + TA && k < 12 + TA + 8) MISO = rx[7 - (k - 12 - TA)];
         else                                       MISO = 1'($urandom);
         if (k == abort_at) begin
            rst_n     = 1'b0;
            cmd_valid = 1'b0;
            return;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] w;
      rst_n     = 1'b0;
      cmd_valid = 1'b1;
      cmd_word  = 10'b00_1101_0100;
      MISO      = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check1("rst ss_n", SS_n, 1'b1);
      check1("rst mosi", MOSI, 1'b0);
      check1("rst rd_valid", rd_valid, 1'b0);
      check8("rst rd_data", rd_data, 8'h00);
      check1("rst cmd_ready", cmd_ready, 1'b0);
      check1("rst busy", busy, 1'b0);
      rst_n     = 1'b1;
      cmd_valid = 1'b0;
      @(negedge CLK);
      check1("post_rst ss_n", SS_n, 1'b1);
      check1("post_rst busy", busy, 1'b0);

      // Write address
      run_frame(10'b00_1101_0100, 8'h00, 1'b0, -1);
      // Write data held valid, then read address back-to-back
      run_frame(10'b01_1111_0010, 8'h00, 1'b1, -1);
      run_frame(10'b10_1101_0100, 8'h00, 1'b0, -1);
      // Read data with reply F0
      run_frame(10'b11_1010_1100, 8'hF0, 1'b0, -1);

      // Reset during SHIFT while word[3] is on MOSI
      run_frame(10'b00_1101_0100, 8'h00, 1'b0, 8);
      @(negedge CLK);
      exp_rd = 8'h00;
      check1("midrst ss_n", SS_n, 1'b1);
      check1("midrst mosi", MOSI, 1'b0);
      check1("midrst busy", busy, 1'b0);
      check1("midrst rd_valid", rd_valid, 1'b0);
      check8("midrst rd_data", rd_data, 8'h00);
      check1("midrst cmd_ready", cmd_ready, 1'b0);
      rst_n = 1'b1;
      run_frame(10'b00_1101_0100, 8'h00, 1'b0, -1);

      // Random words, held valid under backpressure, random replies
      for (int i = 0; i < 12; i++) begin
         w = 10'($urandom);
         if (i % 3 == 0) w[9:8] = 2'b11;
         run_frame(w, 8'($urandom), 1'b1, -1);
      end
      cmd_valid = 1'b0;
      repeat (3) @(negedge CLK);
      check1("end idle ss_n", SS_n, 1'b1);
      check1("end idle busy", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
